div_unit: RTL and testbench

Iterative restoring divider serving the EX stage for the DIV/DIVU class of instructions. Width is set by parameter, and the block supports signed and unsigned modes. It produces a {remainder, quotient} pair that EX routes to the HI/LO write path (remainder→HI, quotient→LO). While a division is outstanding it asserts a stall request so the pipeline control can hold the earlier stages.

---
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, signed or unsigned,
// result {remainder, quotient} held while start_i stays high. Stalls the pipeline while busy.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_req_o,
  output logic [1:0]         dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] dvd_sr;
  logic [WIDTH-1:0] dvs;
  logic             sign1;
  logic             sign2;
  logic             signed_mode;

  logic [WIDTH:0]   pr_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Handshake: start_i is a level request held until ready_o; the result is
  // consumed when start_i drops while ready_o=1. annul_i only cancels work in flight.
  assign stall_req_o = start_i & ~ready_o;
  assign dbg_state_o = state;

  assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  // dvd_sr starts as the dividend magnitude and fills with quotient bits from the bottom.
  assign pr_sh = {pr[WIDTH-1:0], dvd_sr[WIDTH-1]};
  assign diff  = pr_sh - {1'b0, dvs};
  assign q_bit = (pr_sh >= {1'b0, dvs});

  // Most-negative / -1 needs no special case: the negated magnitude wraps to itself.
  assign quo_fix = (signed_mode && (sign1 ^ sign2)) ? (~dvd_sr + 1'b1) : dvd_sr;
  assign rem_fix = (signed_mode && sign1) ? (~pr[WIDTH-1:0] + 1'b1) : pr[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pr          <= '0;
      dvd_sr      <= '0;
      dvs         <= '0;
      sign1       <= 1'b0;
      sign2       <= 1'b0;
      signed_mode <= 1'b0;
      result_o    <= '0;
      ready_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            cnt         <= '0;
            pr          <= '0;
            dvd_sr      <= mag1;
            dvs         <= mag2;
            sign1       <= opdata1_i[WIDTH-1];
            sign2       <= opdata2_i[WIDTH-1];
            signed_mode <= signed_div_i;
            state       <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          // Held two edges so ready_o rises exactly two edges after accept.
          if (annul_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            cnt <= CW'(1);
          end else begin
            state    <= S_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(WIDTH)) begin
            state    <= S_END;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end else begin
            pr     <= q_bit ? diff : pr_sh;
            dvd_sr <= {dvd_sr[WIDTH-2:0], q_bit};
            cnt    <= cnt + 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table on a 32-bit instance, hand sequences for
// annul and asynchronous reset, and an 8-bit instance checked against a behavioural model.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, annul32 = 1'b0, sd32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic        rdy32, stall32;
  logic [1:0]  st32;

  logic        start8 = 1'b0, annul8 = 1'b0, sd8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic        rdy8, stall8;
  logic [1:0]  st8;

  div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .annul_i(annul32), .signed_div_i(sd32),
    .opdata1_i(a32), .opdata2_i(b32), .result_o(res32), .ready_o(rdy32),
    .stall_req_o(stall32), .dbg_state_o(st32)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .signed_div_i(sd8),
    .opdata1_i(a8), .opdata2_i(b8), .result_o(res8), .ready_o(rdy8),
    .stall_req_o(stall8), .dbg_state_o(st8)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1. Issues a request, scrambles operands after accept, waits
  // for ready, checks stall/latency/hold, then releases start and checks the clear.
  task automatic run32(input string name, input logic sd, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                       input int hold);
    int   lat;
    logic stall_bad;
    start32 = 1'b1; sd32 = sd; a32 = a; b32 = b;
    @(posedge clk); #1;
    a32 = $urandom; b32 = $urandom; sd32 = ~sd;
    lat = 0; stall_bad = 1'b0;
    while (!rdy32 && lat < 100) begin
      if (!stall32) stall_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_stall"}, {63'd0, stall_bad}, 64'd0);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_res"}, res32, exp);
    chk({name, "_stall_done"}, {63'd0, stall32}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold"}, {rdy32, res32[62:0]}, {1'b1, exp[62:0]});
    end
    start32 = 1'b0;
    @(posedge clk); #1;
    chk({name, "_clear"}, {63'd0, rdy32} | res32, 64'd0);
  endtask

  task automatic run8(input string name, input logic sd, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp, input int exp_lat,
                      input int hold);
    int lat;
    start8 = 1'b1; sd8 = sd; a8 = a; b8 = b;
    @(posedge clk); #1;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!rdy8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_res"}, 64'(res8), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_held"}, {47'd0, rdy8, res8}, {47'd0, 1'b1, exp});
    start8 = 1'b0;
    @(posedge clk); #1;
    chk({name, "_clear"}, {47'd0, rdy8, res8}, 64'd0);
  endtask

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 33});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33});
    vecs.push_back('{1'b0, 32'd5,          32'd0,          32'h00000000, 32'h00000000, 2});
    vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33});
    vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001, 32'h00000001, 33});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003, 32'hFFFFFFFF, 33});
    vecs.push_back('{1'b0, 32'd7,          32'hFFFFFFFE,   32'h00000000, 32'h00000007, 33});
    vecs.push_back('{1'b1, 32'd0,          32'd5,          32'h00000000, 32'h00000000, 33});
    vecs.push_back('{1'b1, 32'hFFFFFFF8,   32'd0,          32'h00000000, 32'h00000000, 2});
    vecs.push_back('{1'b1, 32'h80000000,   32'd2,          32'hC0000000, 32'h00000000, 33});
    vecs.push_back('{1'b0, 32'd1000,       32'd1000,       32'h00000001, 32'h00000000, 33});
    vecs.push_back('{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 33});

    #23;
    chk("reset_state32", {61'd0, st32, rdy32} | res32, 64'd0);
    chk("reset_state8", {45'd0, st8, rdy8, res8}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      run32($sformatf("vec%0d", i), vecs[i].sd, vecs[i].a, vecs[i].b,
            {vecs[i].r, vecs[i].q}, vecs[i].lat, i % 3);

    // Annul on the tenth ON cycle: back to IDLE next edge, no result ever.
    begin
      logic seen;
      start32 = 1'b1; sd32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
      @(posedge clk); #1;
      repeat (10) begin @(posedge clk); #1; end
      annul32 = 1'b1;
      @(posedge clk); #1;
      chk("annul_idle", {61'd0, st32, rdy32}, 64'd0);
      annul32 = 1'b0; start32 = 1'b0;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (rdy32) seen = 1'b1;
      end
      chk("annul_no_ready", {63'd0, seen}, 64'd0);
      run32("after_annul", 1'b0, 32'd30, 32'd4, {32'd2, 32'd7}, 33, 1);
    end

    // Asynchronous reset mid-ON and in END, then a normal division.
    start32 = 1'b1; sd32 = 1'b0; a32 = 32'd9; b32 = 32'd3;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1 chk("rst_on", {61'd0, st32, rdy32} | res32, 64'd0);
    start32 = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    chk("end_reached", {63'd0, rdy32}, 64'd1);
    annul32 = 1'b1;
    @(posedge clk); #1;
    chk("annul_in_end", {rdy32, res32[62:0]}, {1'b1, 31'd0, 32'd3});
    annul32 = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_end", {61'd0, st32, rdy32} | res32, 64'd0);
    start32 = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    run32("after_rst", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

    run8("w8_200_3", 1'b0, 8'd200, 8'd3, {8'd2, 8'd66}, 9, 1);

    // Random 8-bit operands against a truncating-division model, with varied hold in END.
    for (int i = 0; i < 60; i++) begin
      logic        sd;
      logic [7:0]  a, b, q, r;
      int          ai, bi;
      sd = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      b  = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (i == 5) begin sd = 1'b1; a = 8'h80; b = 8'hFF; end
      ai = sd ? int'($signed(a)) : int'(a);
      bi = sd ? int'($signed(b)) : int'(b);
      if (b == 8'd0) begin
        q = 8'd0; r = 8'd0;
      end else begin
        q = 8'(ai / bi); r = 8'(ai % bi);
      end
      run8($sformatf("rnd%0d", i), sd, a, b, {r, q}, (b == 8'd0) ? 2 : 9,
           $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
